// File: rtl/alu_shared_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier that borrows
// the execute-stage ALU: default widths, the ALU add code and FSM states.
package alu_shared_multiplier_pkg;

    // Operand width used by the execute stage; the product is twice this.
    localparam int DEF_WIDTH = 32;

    // ALU function code the execute stage presents while the multiplier is busy.
    localparam logic [2:0] DEF_ALU_ADD = 3'b010;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/alu_shared_multiplier_negate64.sv
// Combinational conditional two's complement of the double-width product.
// Used in the SIGN state so the final sign fix-up never touches the shared ALU.
module alu_shared_multiplier_negate64 #(
    parameter int WIDTH = 32
) (
    input  logic                 negate,
    input  logic [2*WIDTH-1:0]   value,
    output logic [2*WIDTH-1:0]   result
);

    // Invert-and-increment across the full product when the signs differ.
    always_comb begin
        result = value;
        if (negate) begin
            result = ~value + (2*WIDTH)'(1);
        end
    end

endmodule

// File: rtl/alu_shared_multiplier.sv
// Iterative shift-add multiplier for the execute stage. Each of the WIDTH
// iterations adds the multiplicand magnitude into the upper accumulator using
// the pipeline's own ALU (ALU_A + ALU_B -> ALUOut), recovers the carry-out
// locally from the operand/result MSBs, then shifts the 2*WIDTH+1 bit value
// right by one. Signed operation works on magnitudes and fixes the sign at
// the end, so -2^(WIDTH-1) is handled as the unsigned magnitude 2^(WIDTH-1).
module alu_shared_multiplier
    import alu_shared_multiplier_pkg::*;
#(
    parameter int         WIDTH   = DEF_WIDTH,
    parameter logic [2:0] ALU_ADD = DEF_ALU_ADD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MultE,
    input  logic             MultSgn,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             ALU_zero,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             completed,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t        state;
    logic               mult_e_q;
    logic               start;
    logic               neg_a;
    logic               neg_b;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [2*WIDTH-1:0] signed_product;

    // The ALU zero flag and function code are part of the execute-stage
    // interface but carry no information this sequencer needs.
    logic unused_interface;
    assign unused_interface = ALU_zero ^ (^ALU_ADD);

    // Rising edge of the request level launches an operation.
    assign start = MultE & ~mult_e_q;

    // Operand signs and magnitudes, captured only on the launch edge.
    assign neg_a_in = MultSgn & SrcAE[WIDTH-1];
    assign neg_b_in = MultSgn & SrcBE[WIDTH-1];
    assign mag_a_in = neg_a_in ? (~SrcAE + WIDTH'(1)) : SrcAE;
    assign mag_b_in = neg_b_in ? (~SrcBE + WIDTH'(1)) : SrcBE;

    // Drive the shared ALU operands only while iterating; zero otherwise.
    always_comb begin
        ALU_A = '0;
        ALU_B = '0;
        if (state == ITER) begin
            ALU_A = acc_hi;
            ALU_B = acc_lo[0] ? mag_a : '0;
        end
    end

    // Carry-out of the ALU add rebuilt from the operand and sum MSBs.
    assign carry = (ALU_A[WIDTH-1] & ALU_B[WIDTH-1])
                 | ((ALU_A[WIDTH-1] | ALU_B[WIDTH-1]) & ~ALUOut[WIDTH-1]);

    alu_shared_multiplier_negate64 #(
        .WIDTH (WIDTH)
    ) u_negate (
        .negate (neg_a ^ neg_b),
        .value  ({acc_hi, acc_lo}),
        .result (signed_product)
    );

    // Request edge detector plus the IDLE/ITER/SIGN/DONE sequencer with
    // registered hi/lo, completed and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mult_e_q  <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            mag_a     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            completed <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mult_e_q <= MultE;
            case (state)
                IDLE: begin
                    completed <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        neg_a  <= neg_a_in;
                        neg_b  <= neg_b_in;
                        mag_a  <= mag_a_in;
                        acc_hi <= '0;
                        acc_lo <= mag_b_in;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    acc_hi <= {carry, ALUOut[WIDTH-1:1]};
                    acc_lo <= {ALUOut[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    hi        <= signed_product[2*WIDTH-1:WIDTH];
                    lo        <= signed_product[WIDTH-1:0];
                    completed <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    completed <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_shared_multiplier.md
Name: alu_shared_multiplier

Overview:
- Iterative shift-add 32x32 multiplier that sits in the execute stage and borrows the execute ALU for its 32-bit additions.
- Receives a start pulse, drives the ALU operand muxes through ALU_A and ALU_B, and consumes ALUOut.
- Produces a 64-bit HI/LO product and a one-cycle completion strobe, which the hazard unit uses to release the pipeline stall.
- Supports signed (MULT) and unsigned (MULTU) operation.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH.
- ALU_ADD, 3'b010: ALU function code the execute stage must present while busy=1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- MultE  in  1  multiply request level from the execute stage register.
- MultSgn  in  1  1 = signed operands, 0 = unsigned; sampled at start.
- SrcAE  in  WIDTH  multiplicand after forwarding; sampled at start.
- SrcBE  in  WIDTH  multiplier after forwarding; sampled at start.
- ALUOut  in  WIDTH  ALU sum of ALU_A + ALU_B.
- ALU_zero  in  1  ALU zero flag; unused, present for interface compatibility.
- ALU_A  out  WIDTH  ALU operand A while busy, else 0.
- ALU_B  out  WIDTH  ALU operand B while busy, else 0.
- hi  out  WIDTH  upper product word.
- lo  out  WIDTH  lower product word.
- completed  out  1  one-cycle strobe: hi/lo are valid.
- busy  out  1  high from the cycle after start until DONE is exited; the execute stage muxes the ALU to ALU_A/ALU_B while high.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - hi, lo, ALU_A, ALU_B, and all internal accumulators are 0.
  - completed=0, busy=0.
  - Edge-detect flop is 0.
  - Reset mid-operation abandons the operation; no completed strobe is issued.
- Start:
  - start = MultE & ~MultE_q, where MultE_q is MultE registered.
  - Start is accepted only in IDLE. A held-high MultE does not relaunch; start in any other state is ignored.
- Edge 0, start accepted:
  - Latch sign flags. The negative flag is set only if MultSgn=1 and the operand MSB=1.
  - Latch magnitudes: the two's-complement absolute value when the negative flag is set, else the raw value.
  - acc_hi=0, acc_lo = |SrcBE|, cnt=0. Go to ITER.
- ITER, 32 cycles:
  - ALU_A = acc_hi.
  - ALU_B = |SrcAE| if acc_lo[0]=1, else 0.
  - Carry is computed locally from operand and result MSBs: c = (a&b) | ((a|b) & ~s).
  - At the edge: {acc_hi, acc_lo} <= {c, ALUOut, acc_lo} >> 1; cnt++.
  - At cnt=WIDTH-1 go to SIGN.
- SIGN, 1 cycle:
  - If negA XOR negB, {hi, lo} <= 64-bit two's complement of {acc_hi, acc_lo}; else {hi, lo} <= {acc_hi, acc_lo}.
  - Negation is internal; the ALU is not used. ALU_A = ALU_B = 0. Go to DONE.
- DONE, 1 cycle: completed=1, busy=1. Next edge goes to IDLE.
- Latency: completed is high during the cycle after edge 33, counting the start-sampling edge as 0. Throughput is one product per 35 cycles.
- hi/lo hold their value until the next SIGN state; they are not cleared by start.
- Operand changes on SrcAE/SrcBE/MultSgn after the start edge have no effect.
- ALU_zero is ignored.
- Signed -2^31 magnitude is 2^31 and fits unsigned WIDTH; the result is correct without overflow.

Decomposition:
- Shared header mips_defs.vh holds the state encodings (IDLE, ITER, SIGN, DONE), ALU_ADD, and WIDTH.
- One natural sub-module: mult_negate64, the combinational 64-bit conditional two's-complement used in SIGN.
- Magnitude extraction reuses mult_negate64's 32-bit slice logic inline.

Test Plan:
- Unsigned 7 x 6, MultSgn=0 -> completed at edge 34 with hi=0x00000000, lo=0x0000002A; ALU_B alternates 0 and 7 per multiplier bits.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; exercises the local carry every iteration.
- Signed -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- MultE held high for 50 cycles -> exactly one completed pulse. A fresh 0->1 pulse during ITER is ignored. A new pulse after return to IDLE produces a second result.
- rst_n low at cycle 10 of ITER -> all outputs 0 immediately, no completed strobe. The next start yields a correct product (12 x 12 -> lo=0x90).
